// File: rtl/p300_trial_sequencer_pkg.sv
// Shared types and elaboration helpers for the P300 trial sequencer slice.
// Holds the FSM state encoding, a width helper and the parameter legality rule.
package p300_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DECIDE = 2'd2
  } state_e;

  // Counter width for a value range of n, never narrower than one bit.
  function automatic int w_of(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic bit params_legal(input int num_targets, input int rounds,
                                      input int isi_cycles, input int flash_cycles,
                                      input int win_start, input int win_len);
    return (num_targets >= 2) && (num_targets <= 16) &&
           (rounds >= 1) && (rounds <= 15) &&
           (flash_cycles < isi_cycles) &&
           (win_len >= 1) &&
           (win_start + win_len <= isi_cycles);
  endfunction

endpackage

// File: rtl/p300_trial_sequencer_if.sv
// Control/stimulus/result bundle between the trial sequencer and its neighbours.
// The master side is the trial owner (host + detector), the slave side is the sequencer.
interface p300_trial_sequencer_if
  import p300_pkg::*;
#(
  parameter int NUM_TARGETS = 6
);
  localparam int IDW = w_of(NUM_TARGETS);

  logic           start;
  logic           abort;
  logic           det_in;
  logic           flash;
  logic [IDW-1:0] flash_id;
  logic           det_arm;
  logic           busy;
  logic           done;
  logic [IDW-1:0] result_id;
  logic           result_valid;
  logic           result_tie;

  modport master (
    output start, abort, det_in,
    input  flash, flash_id, det_arm, busy, done, result_id, result_valid, result_tie
  );

  modport slave (
    input  start, abort, det_in,
    output flash, flash_id, det_arm, busy, done, result_id, result_valid, result_tie
  );

endinterface

// File: rtl/p300_trial_sequencer_argmax.sv
// Sequential arg-max scanner: one target per cycle while go is high, lowest index
// wins ties, results registered and held until clear.
module p300_argmax
  import p300_pkg::*;
#(
  parameter int NUM_TARGETS = 6,
  parameter int HW          = 3,
  localparam int IDW        = w_of(NUM_TARGETS)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            clear,
  input  logic                            go,
  input  logic [NUM_TARGETS-1:0][HW-1:0]  hits,
  output logic                            last,
  output logic [IDW-1:0]                  idx,
  output logic                            valid,
  output logic                            tie,
  output logic                            done
);

  localparam logic [IDW-1:0] ID_LAST = IDW'(NUM_TARGETS - 1);

  logic [IDW-1:0] scan_q, scan_d;
  logic [HW-1:0]  max_q, max_d;
  logic [IDW-1:0] run_idx_q, run_idx_d;
  logic           run_tie_q, run_tie_d;
  logic [IDW-1:0] idx_q, idx_d;
  logic           valid_q, valid_d;
  logic           tie_q, tie_d;
  logic           done_q, done_d;
  logic [HW-1:0]  cur;

  assign cur  = hits[scan_q];
  assign last = go && (scan_q == ID_LAST);

  // The running max/tie are folded with the current compare so the final
  // result can be latched in the same cycle as the last compare.
  always_comb begin
    scan_d    = scan_q;
    max_d     = max_q;
    run_idx_d = run_idx_q;
    run_tie_d = run_tie_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    tie_d     = tie_q;
    done_d    = 1'b0;
    if (clear) begin
      scan_d    = '0;
      max_d     = '0;
      run_idx_d = '0;
      run_tie_d = 1'b0;
      idx_d     = '0;
      valid_d   = 1'b0;
      tie_d     = 1'b0;
    end else if (go) begin
      if ((scan_q == '0) || (cur > max_q)) begin
        max_d     = cur;
        run_idx_d = scan_q;
        run_tie_d = 1'b0;
      end else if (cur == max_q) begin
        run_tie_d = 1'b1;
      end
      scan_d = last ? '0 : scan_q + IDW'(1);
      if (last) begin
        done_d = 1'b1;
        if (max_d == '0) begin
          idx_d   = '0;
          valid_d = 1'b0;
          tie_d   = 1'b0;
        end else begin
          idx_d   = run_idx_d;
          valid_d = 1'b1;
          tie_d   = run_tie_d;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_q    <= '0;
      max_q     <= '0;
      run_idx_q <= '0;
      run_tie_q <= 1'b0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      tie_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      scan_q    <= scan_d;
      max_q     <= max_d;
      run_idx_q <= run_idx_d;
      run_tie_q <= run_tie_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      tie_q     <= tie_d;
      done_q    <= done_d;
    end
  end

  assign idx   = idx_q;
  assign valid = valid_q;
  assign tie   = tie_q;
  assign done  = done_q;

endmodule

// File: rtl/p300_trial_sequencer.sv
// P300 trial controller: schedules flash slots over all targets and rounds, counts
// one windowed detection per slot, then hands the hit table to the arg-max scanner.
module p300_trial_sequencer
  import p300_pkg::*;
#(
  parameter int NUM_TARGETS  = 6,
  parameter int ROUNDS       = 4,
  parameter int ISI_CYCLES   = 200,
  parameter int FLASH_CYCLES = 20,
  parameter int WIN_START    = 60,
  parameter int WIN_LEN      = 100
) (
  input  logic                  clk,
  input  logic                  reset,
  p300_trial_sequencer_if.slave bus
);

  localparam int IDW = w_of(NUM_TARGETS);
  localparam int HW  = w_of(ROUNDS + 1);
  localparam int RW  = w_of(ROUNDS);
  localparam int TW  = w_of(ISI_CYCLES + 1);

  localparam logic [TW-1:0]  T_LAST  = TW'(ISI_CYCLES - 1);
  localparam logic [TW-1:0]  FLASH_T = TW'(FLASH_CYCLES);
  localparam logic [TW-1:0]  WIN_LO  = TW'(WIN_START);
  localparam logic [TW-1:0]  WIN_HI  = TW'(WIN_START + WIN_LEN);
  localparam logic [IDW-1:0] ID_LAST = IDW'(NUM_TARGETS - 1);
  localparam logic [RW-1:0]  R_LAST  = RW'(ROUNDS - 1);

  if (!params_legal(NUM_TARGETS, ROUNDS, ISI_CYCLES, FLASH_CYCLES, WIN_START, WIN_LEN))
  begin : g_param_check
    $error("p300_trial_sequencer: illegal parameter combination");
  end

  state_e                         state_q, state_d;
  logic [TW-1:0]                  t_q, t_d;
  logic [RW-1:0]                  round_q, round_d;
  logic [IDW-1:0]                 flash_id_q, flash_id_d;
  logic                           hit_flag_q, hit_flag_d;
  logic                           det_q;
  logic [NUM_TARGETS-1:0][HW-1:0] hits_q, hits_d;

  logic           start_ok, abort_act, slot_end, trial_end, hit_now;
  logic           flash_w, arm_w, busy_w;
  logic           am_last, am_done, am_valid, am_tie;
  logic [IDW-1:0] am_idx;

  // A start is refused in the done cycle so back-to-back trials keep one idle cycle.
  assign start_ok  = (state_q == ST_IDLE) && bus.start && !bus.abort && !am_done;
  assign abort_act = bus.abort && (state_q != ST_IDLE);
  assign slot_end  = (state_q == ST_RUN) && (t_q == T_LAST);
  assign trial_end = slot_end && (flash_id_q == ID_LAST) && (round_q == R_LAST);
  assign hit_now   = bus.det_in && !det_q && arm_w;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start_ok) state_d = ST_RUN;
      ST_RUN:    if (abort_act) state_d = ST_IDLE;
                 else if (trial_end) state_d = ST_DECIDE;
      ST_DECIDE: if (abort_act || am_last) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_w  = (state_q != ST_IDLE);
    flash_w = (state_q == ST_RUN) && (t_q < FLASH_T);
    arm_w   = (state_q == ST_RUN) && (t_q >= WIN_LO) && (t_q < WIN_HI);
  end

  // Slot timing and hit capture; the increment indexes with the pre-wrap flash_id.
  always_comb begin
    t_d        = t_q;
    round_d    = round_q;
    flash_id_d = flash_id_q;
    hit_flag_d = hit_flag_q;
    hits_d     = hits_q;
    if (start_ok || abort_act) begin
      t_d        = '0;
      round_d    = '0;
      flash_id_d = '0;
      hit_flag_d = 1'b0;
      hits_d     = '0;
    end else if (state_q == ST_RUN) begin
      if (hit_now && !hit_flag_q) hits_d[flash_id_q] = hits_q[flash_id_q] + HW'(1);
      if (slot_end) begin
        t_d        = '0;
        hit_flag_d = 1'b0;
        if (flash_id_q == ID_LAST) begin
          flash_id_d = '0;
          round_d    = (round_q == R_LAST) ? '0 : round_q + RW'(1);
        end else begin
          flash_id_d = flash_id_q + IDW'(1);
        end
      end else begin
        t_d        = t_q + TW'(1);
        hit_flag_d = hit_flag_q | hit_now;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      t_q        <= '0;
      round_q    <= '0;
      flash_id_q <= '0;
      hit_flag_q <= 1'b0;
      det_q      <= 1'b0;
      hits_q     <= '0;
    end else begin
      t_q        <= t_d;
      round_q    <= round_d;
      flash_id_q <= flash_id_d;
      hit_flag_q <= hit_flag_d;
      det_q      <= bus.det_in;
      hits_q     <= hits_d;
    end
  end

  p300_argmax #(
    .NUM_TARGETS (NUM_TARGETS),
    .HW          (HW)
  ) u_argmax (
    .clk   (clk),
    .reset (reset),
    .clear (start_ok || abort_act),
    .go    (state_q == ST_DECIDE),
    .hits  (hits_q),
    .last  (am_last),
    .idx   (am_idx),
    .valid (am_valid),
    .tie   (am_tie),
    .done  (am_done)
  );

  assign bus.flash        = flash_w;
  assign bus.flash_id     = flash_id_q;
  assign bus.det_arm      = arm_w;
  assign bus.busy         = busy_w;
  assign bus.done         = am_done;
  assign bus.result_id    = am_idx;
  assign bus.result_valid = am_valid;
  assign bus.result_tie   = am_tie;

endmodule

// File: tb/tb_p300_trial_sequencer.sv
// Randomised bench for p300_trial_sequencer: per-trial det_in waveforms, an
// arithmetic reference model, and a done-triggered result scoreboard.
module tb_p300_trial_sequencer;

  localparam int N    = 3;
  localparam int R    = 2;
  localparam int ISI  = 20;
  localparam int FL   = 4;
  localparam int WS   = 6;
  localparam int WL   = 8;
  localparam int NRI  = N * R * ISI;
  localparam int LAST = NRI + N + 1;

  typedef struct {
    int id;
    int valid;
    int tie;
    int cyc;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   failures;
  bit   wave [0:NRI];
  exp_t sb [$];

  p300_trial_sequencer_if #(.NUM_TARGETS(N)) bus ();

  p300_trial_sequencer #(
    .NUM_TARGETS  (N),
    .ROUNDS       (R),
    .ISI_CYCLES   (ISI),
    .FLASH_CYCLES (FL),
    .WIN_START    (WS),
    .WIN_LEN      (WL)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s at cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_busy"},         int'(bus.busy),         0);
    checkOutput({tag, "_flash"},        int'(bus.flash),        0);
    checkOutput({tag, "_det_arm"},      int'(bus.det_arm),      0);
    checkOutput({tag, "_flash_id"},     int'(bus.flash_id),     0);
    checkOutput({tag, "_done"},         int'(bus.done),         0);
    checkOutput({tag, "_result_id"},    int'(bus.result_id),    0);
    checkOutput({tag, "_result_valid"}, int'(bus.result_valid), 0);
    checkOutput({tag, "_result_tie"},   int'(bus.result_tie),   0);
  endtask

  task automatic clear_wave();
    foreach (wave[i]) wave[i] = 1'b0;
  endtask

  task automatic add_pulse(input int slot, input int t0, input int len);
    for (int i = 0; i < len; i++) begin
      int c;
      c = slot * ISI + t0 + 1 + i;
      if (c <= NRI) wave[c] = 1'b1;
    end
  endtask

  // Reference: one hit per slot for the first in-window rise, then arg-max.
  task automatic model(output exp_t e);
    int h [N];
    int mx;
    int cnt;
    bit got;
    foreach (h[i]) h[i] = 0;
    for (int s = 0; s < N * R; s++) begin
      got = 1'b0;
      for (int t = 0; t < ISI; t++) begin
        int c;
        c = s * ISI + t + 1;
        if (wave[c] && !wave[c-1] && t >= WS && t < WS + WL && !got) begin
          got = 1'b1;
          h[s % N]++;
        end
      end
    end
    mx   = 0;
    e.id = 0;
    for (int i = 0; i < N; i++) if (h[i] > mx) begin mx = h[i]; e.id = i; end
    cnt = 0;
    for (int i = 0; i < N; i++) if (h[i] == mx) cnt++;
    e.valid = (mx > 0) ? 1 : 0;
    e.tie   = (mx > 0 && cnt > 1) ? 1 : 0;
    e.cyc   = 0;
  endtask

  // One trial from the current negedge; optional abort/reset cycle, ignored start
  // pulse while busy, and a start attempt in the done cycle.
  task automatic applyStimulus(input int abort_c, input int reset_c, input int ign_c,
                               input bit chain);
    exp_t e;
    int   t;
    int   slot;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    model(e);
    e.cyc = cyc + LAST - 1;
    if (abort_c == 0 && reset_c == 0) sb.push_back(e);
    for (int c = 1; c <= LAST; c++) begin
      t    = (c - 1) % ISI;
      slot = (c - 1) / ISI;
      checkOutput("busy",    int'(bus.busy),    int'(c <= NRI + N));
      checkOutput("flash",   int'(bus.flash),   int'(c <= NRI && t < FL));
      checkOutput("det_arm", int'(bus.det_arm), int'(c <= NRI && t >= WS && t < WS + WL));
      if (c <= NRI) checkOutput("flash_id", int'(bus.flash_id), slot % N);
      if (c == abort_c) begin
        bus.abort  = 1'b1;
        bus.det_in = 1'b0;
        bus.start  = 1'b0;
        @(negedge clk);
        bus.abort = 1'b0;
        checkOutput("abort_busy",    int'(bus.busy),         0);
        checkOutput("abort_flash",   int'(bus.flash),        0);
        checkOutput("abort_det_arm", int'(bus.det_arm),      0);
        checkOutput("abort_valid",   int'(bus.result_valid), 0);
        repeat (LAST) @(negedge clk);
        checkOutput("abort_still_idle", int'(bus.busy), 0);
        return;
      end
      if (c == reset_c) begin
        bus.det_in = 1'b0;
        bus.start  = 1'b0;
        #2 reset = 1'b1;
        #1 check_all_zero("async_reset");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        return;
      end
      bus.det_in = (c <= NRI) ? wave[c] : 1'b0;
      bus.start  = (c == ign_c) || (c == LAST && chain);
      @(negedge clk);
    end
    bus.start = 1'b0;
    checkOutput("done_one_cycle", int'(bus.done), 0);
    if (chain) checkOutput("start_in_done_ignored", int'(bus.busy), 0);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && bus.done) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          checkOutput("done_cycle",   cyc,                    e.cyc);
          checkOutput("result_id",    int'(bus.result_id),    e.id);
          checkOutput("result_valid", int'(bus.result_valid), e.valid);
          checkOutput("result_tie",   int'(bus.result_tie),   e.tie);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int mode;
    int ign;
    cyc        = 0;
    checks     = 0;
    failures   = 0;
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.abort  = 1'b0;
    bus.det_in = 1'b0;
    clear_wave();
    #2 check_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // No detections, then a start in the done cycle that must be ignored.
    clear_wave();
    applyStimulus(0, 0, 0, 1'b1);

    // Target 2 in both rounds, target 0 once; ignored start mid-run.
    clear_wave();
    add_pulse(2, 8, 2); add_pulse(5, 8, 2); add_pulse(0, 8, 2);
    applyStimulus(0, 0, 40, 1'b0);

    // One hit each on targets 1 and 2.
    clear_wave();
    add_pulse(1, 7, 1); add_pulse(2, 7, 1);
    applyStimulus(0, 0, 0, 1'b0);

    // Window edges: t=13 counts, t=5 held and t=14 do not, multi-pulse and hold count once.
    clear_wave();
    add_pulse(0, 13, 1); add_pulse(1, 5, 3); add_pulse(2, 14, 3);
    add_pulse(4, 6, 1);  add_pulse(4, 9, 1); add_pulse(4, 12, 1);
    add_pulse(5, 6, 8);
    applyStimulus(0, 0, 0, 1'b0);

    // Abort at t=10 of slot 3 after target 0 scored twice, then a clean restart.
    clear_wave();
    add_pulse(0, 8, 1); add_pulse(3, 8, 1);
    applyStimulus(71, 0, 0, 1'b0);
    clear_wave();
    add_pulse(1, 9, 2);
    applyStimulus(0, 0, 0, 1'b0);

    // Asynchronous reset in the middle of the slot-1 window.
    clear_wave();
    add_pulse(0, 7, 1);
    applyStimulus(0, 29, 0, 1'b0);

    for (int k = 0; k < 20; k++) begin
      clear_wave();
      for (int s = 0; s < N * R; s++) begin
        mode = $urandom_range(0, 4);
        case (mode)
          1: add_pulse(s, $urandom_range(0, ISI - 1), $urandom_range(1, 3));
          2: add_pulse(s, WS, WL);
          3: begin add_pulse(s, WS, 1); add_pulse(s, WS + 3, 1); add_pulse(s, WS + 6, 1); end
          4: begin add_pulse(s, $urandom_range(0, ISI - 1), 1);
                   add_pulse(s, $urandom_range(0, ISI - 1), 2); end
          default: ;
        endcase
      end
      ign = ($urandom_range(0, 1) == 1) ? $urandom_range(2, NRI + N) : 0;
      applyStimulus(0, 0, ign, $urandom_range(0, 1) == 1);
    end

    repeat (5) @(negedge clk);
    checkOutput("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
